// File: rtl/pinmux_pkg.sv
// pinmux_pkg -- shared definitions for the pin multiplexer.
//   FUNC_GPIO   : function index that is always GPIO.
//   pin_state_e : per-pin switching state (ACTIVE drives, TURN is the
//                 tri-stated dead-time window between two functions).
//   sel_width() : width of a function-select field for a given function count.
package pinmux_pkg;

    localparam int FUNC_GPIO = 0;

    typedef enum logic {
        ACTIVE = 1'b0,
        TURN   = 1'b1
    } pin_state_e;

    // A select field is never narrower than one bit, even for a single function.
    function automatic int sel_width(input int num_funcs);
        return (num_funcs > 1) ? $clog2(num_funcs) : 1;
    endfunction

endpackage

// File: rtl/pinmux_ctrl_if.sv
// pinmux_ctrl_if -- configuration port of the pin multiplexer.
//   cfg_we_i    : write strobe
//   cfg_addr_i  : pin index; address NUM_PINS is the lock register
//   cfg_wdata_i : function select to write
//   cfg_rdata_o : registered committed select of cfg_addr_i
//   lock_o      : configuration locked (sticky until reset)
//   busy_o      : some pin is inside its dead-time window
// master: the configuring agent. slave: pinmux_ctrl.
interface pinmux_ctrl_if
    import pinmux_pkg::*;
#(
    parameter int NUM_PINS  = 32,
    parameter int NUM_FUNCS = 4
);
    localparam int ADDR_W = $clog2(NUM_PINS + 1);
    localparam int SEL_W  = sel_width(NUM_FUNCS);

    logic              cfg_we_i;
    logic [ADDR_W-1:0] cfg_addr_i;
    logic [SEL_W-1:0]  cfg_wdata_i;
    logic [SEL_W-1:0]  cfg_rdata_o;
    logic              lock_o;
    logic              busy_o;

    modport master (
        output cfg_we_i, cfg_addr_i, cfg_wdata_i,
        input  cfg_rdata_o, lock_o, busy_o
    );

    modport slave (
        input  cfg_we_i, cfg_addr_i, cfg_wdata_i,
        output cfg_rdata_o, lock_o, busy_o
    );
endinterface

// File: rtl/pinmux_pin.sv
// pinmux_pin -- one pad's function switch.
//   clk, reset : clock, asynchronous active-high reset
//   wr_en      : qualified write to this pin (lock and range already checked)
//   wr_sel     : requested function
//   func_out   : drive of every function, index 0 = GPIO
//   func_oen   : active-low enable of every function
//   pad_out    : registered pad drive
//   pad_oen    : registered pad enable (1 = high-Z)
//   sel        : committed function
//   active     : pin is not inside its dead-time window
// A function change holds the pad tri-stated for DEAD_CYCLES cycles so the
// outgoing and incoming peripherals never overlap on the pad.
module pinmux_pin
    import pinmux_pkg::*;
#(
    parameter int NUM_FUNCS   = 4,
    parameter int DEAD_CYCLES = 2,
    parameter int SEL_W       = sel_width(NUM_FUNCS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [SEL_W-1:0]     wr_sel,
    input  logic [NUM_FUNCS-1:0] func_out,
    input  logic [NUM_FUNCS-1:0] func_oen,
    output logic                 pad_out,
    output logic                 pad_oen,
    output logic [SEL_W-1:0]     sel,
    output logic                 active
);
    localparam int CNT_W = $clog2(DEAD_CYCLES + 1);

    pin_state_e       state_reg, state_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [SEL_W-1:0] nxt_reg, nxt_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pad_out_reg, pad_out_next;
    logic             pad_oen_reg, pad_oen_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ACTIVE;
            sel_reg     <= SEL_W'(FUNC_GPIO);
            nxt_reg     <= SEL_W'(FUNC_GPIO);
            cnt_reg     <= '0;
            pad_out_reg <= 1'b0;
            pad_oen_reg <= 1'b1;
        end else begin
            state_reg   <= state_next;
            sel_reg     <= sel_next;
            nxt_reg     <= nxt_next;
            cnt_reg     <= cnt_next;
            pad_out_reg <= pad_out_next;
            pad_oen_reg <= pad_oen_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        sel_next     = sel_reg;
        nxt_next     = nxt_reg;
        cnt_next     = cnt_reg;
        pad_out_next = func_out[sel_reg];
        pad_oen_next = func_oen[sel_reg];
        case (state_reg)
            ACTIVE: begin
                // Re-selecting the current function must not glitch the pad.
                if (wr_en && (wr_sel != sel_reg)) begin
                    state_next = TURN;
                    nxt_next   = wr_sel;
                    cnt_next   = CNT_W'(DEAD_CYCLES);
                end
            end
            TURN: begin
                // Idle-high and released while the pad changes owner.
                pad_out_next = 1'b1;
                pad_oen_next = 1'b1;
                // Any write restarts the window, even one naming the old
                // function, so the last requested function always gets a
                // full dead time after the previous request.
                if (wr_en) begin
                    nxt_next = wr_sel;
                    cnt_next = CNT_W'(DEAD_CYCLES);
                end else if (cnt_reg == CNT_W'(1)) begin
                    state_next = ACTIVE;
                    sel_next   = nxt_reg;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            default: state_next = ACTIVE;
        endcase
    end

    assign pad_out = pad_out_reg;
    assign pad_oen = pad_oen_reg;
    assign sel     = sel_reg;
    assign active  = (state_reg == ACTIVE);
endmodule

// File: rtl/pinmux_ctrl.sv
// pinmux_ctrl -- run-time programmable pin multiplexer.
//   clk, reset          : clock, asynchronous active-high reset
//   cfg                 : configuration port (pinmux_ctrl_if.slave)
//   gpio_out_i/oen_i    : GPIO drive / active-low enable per pin
//   gpio_in_o           : pad input to GPIO, always connected
//   fn_out_i/fn_oen_i   : function f (1..NUM_FUNCS-1) on pin p at [(f-1)*NUM_PINS+p]
//   fn_in_o             : pad input per function, 1 when not routed
//   pad_in_i            : from pads
//   pad_out_o/pad_oen_o : registered pad drive / enable (1 = high-Z)
// Build option: IOMUX_INPUT_SYNC_EN adds a 2-flop synchroniser (reset 1) on
// every pad input; otherwise pad inputs route combinationally.
module pinmux_ctrl
    import pinmux_pkg::*;
#(
    parameter int NUM_PINS    = 32,
    parameter int NUM_FUNCS   = 4,
    parameter int DEAD_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    pinmux_ctrl_if.slave                      cfg,
    input  logic [NUM_PINS-1:0]               gpio_out_i,
    input  logic [NUM_PINS-1:0]               gpio_oen_i,
    output logic [NUM_PINS-1:0]               gpio_in_o,
    input  logic [(NUM_FUNCS-1)*NUM_PINS-1:0] fn_out_i,
    input  logic [(NUM_FUNCS-1)*NUM_PINS-1:0] fn_oen_i,
    output logic [(NUM_FUNCS-1)*NUM_PINS-1:0] fn_in_o,
    input  logic [NUM_PINS-1:0]               pad_in_i,
    output logic [NUM_PINS-1:0]               pad_out_o,
    output logic [NUM_PINS-1:0]               pad_oen_o
);
    localparam int ADDR_W = $clog2(NUM_PINS + 1);
    localparam int SEL_W  = sel_width(NUM_FUNCS);

    logic                lock_reg;
    logic                busy_reg;
    logic [SEL_W-1:0]    rdata_reg, rdata_next;
    logic                wdata_ok, pin_wr_ok, lock_wr;
    logic [NUM_PINS-1:0] pad_in_s;
    logic [NUM_PINS-1:0] pin_active;
    logic [SEL_W-1:0]    pin_sel [NUM_PINS];

    // Selects beyond the implemented functions only exist when NUM_FUNCS
    // is not a power of two; such writes are dropped.
    assign wdata_ok  = 32'(cfg.cfg_wdata_i) < NUM_FUNCS;
    assign pin_wr_ok = cfg.cfg_we_i && !lock_reg && wdata_ok;
    assign lock_wr   = cfg.cfg_we_i && !lock_reg && (cfg.cfg_addr_i == ADDR_W'(NUM_PINS));

    // Only pin addresses read back; the lock address and beyond read 0.
    always_comb begin
        rdata_next = '0;
        for (int p = 0; p < NUM_PINS; p++) begin
            if (cfg.cfg_addr_i == ADDR_W'(p)) rdata_next = pin_sel[p];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            rdata_reg <= '0;
        end else begin
            if (lock_wr) lock_reg <= 1'b1;
            busy_reg  <= ~&pin_active;
            rdata_reg <= rdata_next;
        end
    end

`ifdef IOMUX_INPUT_SYNC_EN
    logic [NUM_PINS-1:0] sync1_reg, sync2_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= '1;
            sync2_reg <= '1;
        end else begin
            sync1_reg <= pad_in_i;
            sync2_reg <= sync1_reg;
        end
    end

    assign pad_in_s = sync2_reg;
`else
    assign pad_in_s = pad_in_i;
`endif

    assign gpio_in_o = pad_in_s;

    genvar gi, gf;
    generate
        for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
            logic [NUM_FUNCS-1:0] func_out, func_oen;

            assign func_out[FUNC_GPIO] = gpio_out_i[gi];
            assign func_oen[FUNC_GPIO] = gpio_oen_i[gi];

            for (gf = 1; gf < NUM_FUNCS; gf++) begin : g_fn
                assign func_out[gf] = fn_out_i[(gf-1)*NUM_PINS + gi];
                assign func_oen[gf] = fn_oen_i[(gf-1)*NUM_PINS + gi];
                // Unrouted or switching inputs idle high.
                assign fn_in_o[(gf-1)*NUM_PINS + gi] =
                    (pin_active[gi] && (pin_sel[gi] == SEL_W'(gf))) ? pad_in_s[gi] : 1'b1;
            end

            pinmux_pin #(
                .NUM_FUNCS   (NUM_FUNCS),
                .DEAD_CYCLES (DEAD_CYCLES),
                .SEL_W       (SEL_W)
            ) u_pin (
                .clk      (clk),
                .reset    (reset),
                .wr_en    (pin_wr_ok && (cfg.cfg_addr_i == ADDR_W'(gi))),
                .wr_sel   (cfg.cfg_wdata_i),
                .func_out (func_out),
                .func_oen (func_oen),
                .pad_out  (pad_out_o[gi]),
                .pad_oen  (pad_oen_o[gi]),
                .sel      (pin_sel[gi]),
                .active   (pin_active[gi])
            );
        end
    endgenerate

    assign cfg.cfg_rdata_o = rdata_reg;
    assign cfg.lock_o      = lock_reg;
    assign cfg.busy_o      = busy_reg;
endmodule

// File: tb/tb_pinmux_ctrl.sv
// tb_pinmux_ctrl -- directed scenarios followed by randomized traffic, every
// cycle compared against a per-pin model of committed function, pending
// function and remaining dead-time cycles.
module tb_pinmux_ctrl;
    localparam int NP   = 32;
    localparam int NF   = 4;
    localparam int DEAD = 2;
    localparam int FW   = (NF - 1) * NP;
    localparam int AW   = $clog2(NP + 1);
    localparam int SW   = $clog2(NF);

    logic          clk = 1'b0;
    logic          reset;
    logic [NP-1:0] gpio_out, gpio_oen, gpio_in, pad_in, pad_out, pad_oen;
    logic [FW-1:0] fn_out, fn_oen, fn_in;

    always #5 clk = ~clk;

    pinmux_ctrl_if #(.NUM_PINS(NP), .NUM_FUNCS(NF)) cfg_if ();

    pinmux_ctrl #(
        .NUM_PINS    (NP),
        .NUM_FUNCS   (NF),
        .DEAD_CYCLES (DEAD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg        (cfg_if),
        .gpio_out_i (gpio_out),
        .gpio_oen_i (gpio_oen),
        .gpio_in_o  (gpio_in),
        .fn_out_i   (fn_out),
        .fn_oen_i   (fn_oen),
        .fn_in_o    (fn_in),
        .pad_in_i   (pad_in),
        .pad_out_o  (pad_out),
        .pad_oen_o  (pad_oen)
    );

    // Reference model
    int            m_sel  [NP];
    int            m_nxt  [NP];
    int            m_left [NP];   // dead-time cycles still to run, 0 = driving
    bit            m_lock;
    logic [NP-1:0] hist0, hist1;  // pad input at the last edge and the one before
    int            checks   = 0;
    int            failures = 0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            m_sel[p]  = 0;
            m_nxt[p]  = 0;
            m_left[p] = 0;
        end
        m_lock = 1'b0;
        hist0  = '1;
        hist1  = '1;
    endtask

    task automatic set_cfg(input bit we, input int addr, input int data);
        cfg_if.cfg_we_i    = we;
        cfg_if.cfg_addr_i  = AW'(addr);
        cfg_if.cfg_wdata_i = SW'(data);
        if (we) $display("cfg write addr=%0d data=%0d t=%0t", addr, data, $time);
    endtask

    // One clock edge: predict registered outputs from the pre-edge model,
    // advance the model, then compare every output.
    task automatic cycle();
        logic [NP-1:0] e_out, e_oen, e_sync;
        logic [FW-1:0] e_fn_in;
        logic          e_busy;
        logic [SW-1:0] e_rd;
        int            a, d, wp;
        e_busy = 1'b0;
        for (int p = 0; p < NP; p++) begin
            if (m_left[p] > 0) begin
                e_out[p] = 1'b1;
                e_oen[p] = 1'b1;
                e_busy   = 1'b1;
            end else if (m_sel[p] == 0) begin
                e_out[p] = gpio_out[p];
                e_oen[p] = gpio_oen[p];
            end else begin
                e_out[p] = fn_out[(m_sel[p] - 1) * NP + p];
                e_oen[p] = fn_oen[(m_sel[p] - 1) * NP + p];
            end
        end
        a    = int'(cfg_if.cfg_addr_i);
        d    = int'(cfg_if.cfg_wdata_i);
        e_rd = (a < NP) ? SW'(m_sel[a]) : '0;
        wp   = -1;
        if (cfg_if.cfg_we_i && !m_lock) begin
            if (a == NP) m_lock = 1'b1;
            else if (a < NP && d < NF) wp = a;
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (p == wp) begin
                if (m_left[p] > 0 || d != m_sel[p]) begin
                    m_nxt[p]  = d;
                    m_left[p] = DEAD;
                end
            end else if (m_left[p] > 0) begin
                m_left[p]--;
                if (m_left[p] == 0) m_sel[p] = m_nxt[p];
            end
        end
        hist1 = hist0;
        hist0 = pad_in;
`ifdef IOMUX_INPUT_SYNC_EN
        e_sync = hist1;
`else
        e_sync = pad_in;
`endif
        for (int f = 1; f < NF; f++)
            for (int p = 0; p < NP; p++)
                e_fn_in[(f - 1) * NP + p] = (m_left[p] == 0 && m_sel[p] == f) ? e_sync[p] : 1'b1;
        check_val("pad_out", 128'(pad_out), 128'(e_out));
        check_val("pad_oen", 128'(pad_oen), 128'(e_oen));
        check_val("busy", 128'(cfg_if.busy_o), 128'(e_busy));
        check_val("rdata", 128'(cfg_if.cfg_rdata_o), 128'(e_rd));
        check_val("lock", 128'(cfg_if.lock_o), 128'(m_lock));
        check_val("gpio_in", 128'(gpio_in), 128'(e_sync));
        check_val("fn_in", 128'(fn_in), 128'(e_fn_in));
    endtask

    // Reset pulse spanning one edge; reset values are checked while asserted.
    task automatic do_reset();
        reset = 1'b1;
        #2;
        check_val("rst_pad_oen", 128'(pad_oen), 128'({NP{1'b1}}));
        check_val("rst_pad_out", 128'(pad_out), 128'(0));
        check_val("rst_busy", 128'(cfg_if.busy_o), 128'(0));
        check_val("rst_lock", 128'(cfg_if.lock_o), 128'(0));
        check_val("rst_rdata", 128'(cfg_if.cfg_rdata_o), 128'(0));
        check_val("rst_fn_in", 128'(fn_in), 128'({FW{1'b1}}));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    int busy_cnt;

    initial begin
        reset    = 1'b1;
        gpio_out = '0;
        gpio_oen = '1;
        fn_out   = '0;
        fn_oen   = '1;
        pad_in   = '1;
        set_cfg(0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // GPIO passes through one cycle after release
        gpio_oen = '0;
        gpio_out = 32'hA5A5A5A5;
        cycle();
        check_val("gpio_pass", 128'(pad_out), 128'(32'hA5A5A5A5));

        // pin 3 -> function 2
        fn_out = {$urandom, $urandom, $urandom};
        fn_oen = {$urandom, $urandom, $urandom};
        set_cfg(1, 3, 2);
        cycle();
        set_cfg(0, 3, 0);
        busy_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (cfg_if.busy_o) busy_cnt++;
        end
        check_val("turn_len", 128'(busy_cnt), 128'(DEAD));
        check_val("rd_pin3", 128'(cfg_if.cfg_rdata_o), 128'(2));
        check_val("pin3_fn2", 128'(pad_out[3]), 128'(fn_out[NP + 3]));

        // pin 5: 1 then 3 one cycle later restarts the window
        set_cfg(1, 5, 1);
        cycle();
        busy_cnt = 0;
        set_cfg(1, 5, 3);
        cycle();
        if (cfg_if.busy_o) busy_cnt++;
        set_cfg(0, 5, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            if (cfg_if.busy_o) busy_cnt++;
        end
        check_val("restart_len", 128'(busy_cnt), 128'(DEAD + 1));
        check_val("rd_pin5", 128'(cfg_if.cfg_rdata_o), 128'(3));

        // lock, then a write to pin 0 is ignored
        set_cfg(1, NP, 0);
        cycle();
        set_cfg(1, 0, 1);
        cycle();
        set_cfg(0, 0, 0);
        for (int i = 0; i < 4; i++) cycle();
        check_val("locked", 128'(cfg_if.lock_o), 128'(1));
        check_val("lock_rd0", 128'(cfg_if.cfg_rdata_o), 128'(0));
        do_reset();

        // pin 7 -> function 1, pad input toggles
        set_cfg(1, 7, 1);
        cycle();
        set_cfg(0, 7, 0);
        for (int i = 0; i < 10; i++) begin
            pad_in[7] = ~pad_in[7];
            cycle();
        end

        // reset in the middle of a switch on pin 9
        set_cfg(1, 9, 2);
        cycle();
        set_cfg(0, 9, 0);
        reset = 1'b1;
        #1;
        check_val("abort_oen", 128'(pad_oen), 128'({NP{1'b1}}));
        check_val("abort_busy", 128'(cfg_if.busy_o), 128'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        cycle();
        cycle();
        check_val("abort_rd9", 128'(cfg_if.cfg_rdata_o), 128'(0));
        check_val("abort_gpio9", 128'(pad_out[9]), 128'(gpio_out[9]));

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int a;
            if (i % 400 == 399) do_reset();
            if ($urandom_range(0, 7) == 0) begin
                gpio_out = $urandom;
                gpio_oen = $urandom;
                fn_out   = {$urandom, $urandom, $urandom};
                fn_oen   = {$urandom, $urandom, $urandom};
            end
            pad_in = $urandom;
            if ($urandom_range(0, 15) == 0) a = $urandom_range(NP, (1 << AW) - 1);
            else a = $urandom_range(0, NP - 1);
            set_cfg($urandom_range(0, 2) == 0, a, $urandom_range(0, NF - 1));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pinmux_ctrl.md
# pinmux_ctrl

Parametrised, run-time programmable pin multiplexer between the SoC peripherals (GPIO, SPI, I2C, UART, PWM) and the pad ring. Each pin carries a function select written through a small config port. A function change passes through a per-pin tri-stated dead-time window, so no pad is ever driven by two sources mid-switch. Pad outputs are registered, and pad inputs are optionally synchronised.

## Interface
Parameters:
- NUM_PINS, 32, number of pads.
- NUM_FUNCS, 4, functions per pin; function 0 is always GPIO.
- DEAD_CYCLES, 2, tri-state cycles on a function change (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cfg_we_i  in  1  config write strobe.
- cfg_addr_i  in  $clog2(NUM_PINS+1)  pin index; address NUM_PINS is the lock register.
- cfg_wdata_i  in  $clog2(NUM_FUNCS)  function select to write.
- cfg_rdata_o  out  $clog2(NUM_FUNCS)  committed select of cfg_addr_i, registered.
- lock_o  out  1  configuration locked.
- busy_o  out  1  any pin in dead-time.
- gpio_out_i / gpio_oen_i  in  NUM_PINS each  GPIO drive / active-low enable.
- gpio_in_o  out  NUM_PINS  pad input to GPIO, always connected.
- fn_out_i / fn_oen_i  in  (NUM_FUNCS-1)*NUM_PINS each  peripheral drive / active-low enable; slice [(f-1)*NUM_PINS+p] is function f on pin p.
- fn_in_o  out  (NUM_FUNCS-1)*NUM_PINS  pad input to each function.
- pad_in_i  in  NUM_PINS  from pad.
- pad_out_o / pad_oen_o  out  NUM_PINS each  to pad; oen is active-low (1 = high-Z).

## Operation
- Each pin has a committed select `sel` and a pending select `nxt`, both reset to 0 (GPIO).
- Per-pin FSM has two states, ACTIVE and TURN:
  - ACTIVE: pad_out/pad_oen come from function `sel`.
  - ACTIVE → TURN: a write whose data ≠ `sel` loads `nxt` and sets the counter to DEAD_CYCLES. A write whose data = `sel` is a no-op.
  - TURN: pad_oen = 1, pad_out = 1, and the counter decrements.
  - TURN, counter = 1 → ACTIVE, with `sel` ← `nxt`.
  - A write during TURN reloads `nxt` and restarts the counter. A write equal to the old `sel` still completes the full TURN.
- Lock: writing any data with cfg_addr_i = NUM_PINS sets lock_o. Lock is sticky and clears only on reset. While locked, all writes are ignored. A pin already in TURN finishes normally.
- Writes to addresses > NUM_PINS are ignored. Reads of such addresses, and of NUM_PINS itself, return 0.
- Input routing:
  - gpio_in_o[p] is the (synced) pad_in[p].
  - fn_in_o for function f on pin p is the pad input when `sel` = f and the pin is ACTIVE; otherwise it is 1 (idle-high, safe for UART rx, SPI miso and I2C).
- Out-of-range writes with cfg_wdata_i ≥ NUM_FUNCS, when NUM_FUNCS is not a power of 2, are ignored.
- busy_o is the OR of all pins in TURN.

## Timing
- Reset values: pad_out_o = 0, pad_oen_o = all 1, lock_o = 0, busy_o = 0, cfg_rdata_o = 0, gpio_in_o/fn_in_o = all 1.
- Pad output path: pad_out_o/pad_oen_o are registered, 1 cycle after the mux inputs.
- Write at edge N:
  - busy_o and the forced pad_oen = 1 appear after edge N+1.
  - The new function drives the pad from edge N+DEAD_CYCLES+1.
- cfg_rdata_o reflects the committed `sel` 1 cycle after the address, so it shows the old value until commit.
- Reset asserted mid-TURN aborts the switch immediately; the pin returns to GPIO.

## Configuration
- IOMUX_INPUT_SYNC_EN defined:
  - 2-flop synchroniser on every pad_in_i bit, reset value 1.
  - gpio_in_o/fn_in_o lag the pad by 2 cycles.
- IOMUX_INPUT_SYNC_EN undefined: the pad input routes combinationally with 0 cycles latency, and gpio_in_o/fn_in_o have no reset value.

## Structure
- Shared package pinmux_pkg:
  - FUNC_GPIO = 0.
  - pin_state_e {ACTIVE, TURN}.
  - sel-width localparam helper function.
- Sub-module pinmux_pin: one instance per pin, generated. It holds the FSM, counter, `sel`/`nxt`, the output mux and the output register.
- The top holds the config decode, lock, input synchroniser, input fan-out, busy reduction and readback register.

## Test plan
- Reset → pad_oen_o = all 1, pad_out_o = 0. One cycle after release, with gpio_oen_i = 0 and gpio_out_i = 0xA5A5A5A5 → pad_out_o = 0xA5A5A5A5.
- Write pin 3 ← func 2 with DEAD_CYCLES = 2 → pad_oen_o[3] = 1 for 2 cycles and busy_o high for 2 cycles; then pad_out_o[3] follows fn_out_i slice for func 2, and cfg_rdata_o for addr 3 = 2.
- Write pin 5 ← 1, then pin 5 ← 3 one cycle later → the counter restarts, only func 3 ever drives, and the total TURN is 3 cycles.
- Write lock (addr NUM_PINS), then write pin 0 ← 1 → lock_o = 1, pin 0 stays GPIO, busy_o stays 0. Reset clears the lock.
- Pin 7 set to func 1, pad_in_i[7] toggles → fn_in_o func 1 follows after 2 cycles (sync on); the func 2/3 slices for pin 7 stay 1; gpio_in_o[7] follows.
- Reset asserted mid-TURN on pin 9 → pin 9 sel = 0, busy_o = 0, pad_oen_o = 1 immediately.
